instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage feeding the decode stage's opcode/funct3/funct7 control decoder. Owns the PC,
//   issues word requests to instruction memory and buffers returned words in a 2-entry FIFO.
//   Presents {instrD, pcD} to decode with a valid/ready handshake.
//   Accepts branch/jump redirects from execute and discards wrong-path words.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC of first fetch after reset; bits [1:0] must be 0
//   FIFO_DEPTH 2              instruction buffer entries; fixed, other values unsupported
// PORTS
//   clk           in   1   clock, all state updates on rising edge
//   rst           in   1   synchronous, active-high reset
//   imem_req      out  1   request valid this cycle; memory always accepts
//   imem_addr     out  32  word-aligned fetch address (= PC)
//   imem_rvalid   in   1   response valid; exactly 1 cycle after the accepted imem_req
//   imem_rdata    in   32  instruction word for the oldest outstanding request
//   redirect      in   1   take redirect_pc this cycle (branch taken / JAL / JALR from execute)
//   redirect_pc   in   32  redirect target; bits [1:0] ignored (forced to 0)
//   validD        out  1   instrD/pcD hold a valid instruction
//   readyD        in   1   decode accepts; transfer occurs when validD & readyD
//   instrD        out  32  instruction word (opcode = [6:0], funct3 = [14:12], funct7 = [31:25])
//   pcD           out  32  address of instrD
// BEHAVIOUR
//   Reset (rst=1 at edge): PC<=RESET_PC, FIFO empty, in-flight cleared, kill cleared.
//     While rst=1: imem_req=0, validD=0; instrD/pcD=0.
//   State: PC (32b), FIFO of {instr,pc} (2 entries, rd/wr ptr + 2b count), inflight (1b),
//     inflight_pc (32b), kill (1b).
//   Request rule (combinational): pop = validD & readyD;
//     imem_req = ~rst & ~redirect & (count + inflight - pop < 2).
//     On request: imem_addr=PC, PC<=PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), inflight_pc<=PC.
//     inflight<=imem_req, i.e. at most 1 outstanding at a time.
//   Response: when imem_rvalid & ~kill, push {imem_rdata, inflight_pc} into FIFO.
//     When imem_rvalid & kill, drop the word; kill<=0.
//     imem_rvalid without inflight is a protocol error; ignore it (no push).
//   Output: validD = (count != 0); instrD/pcD = FIFO head, registered, no rdata bypass.
//     Latency: request at cycle T, response T+1, validD at T+2.
//     Steady-state throughput: 1 instr/cycle with readyD held high.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//     Push never occurs when full (guaranteed by request rule).
//   Redirect (highest priority, any cycle):
//     PC<={redirect_pc[31:2],2'b00}; FIFO flushed (count<=0); no request this cycle.
//     If a response is due next cycle, kill<=1 so it is dropped.
//     A pop in the redirect cycle still completes; decode squashes it itself.
//     A response arriving in the redirect cycle is not pushed.
//     First new request in cycle R+1; new validD in R+3.
//   Back-pressure: readyD=0 holds instrD/pcD stable and validD high. At most 2 words buffered.
//     No word is lost or duplicated.
//   Reset mid-operation: identical to power-on reset. In-flight response in the cycle after
//     reset is dropped (inflight=0 so no push).
// TESTING
//   1 Reset: rst=1 for 3 cycles -> imem_req=0, validD=0.
//     First cycle with rst=0 -> imem_req=1, imem_addr=0x0; validD=1 two cycles later with pcD=0x0.
//   2 Stream: readyD=1, memory returns addr^0xA5A5_0000 ->
//     pcD=0x0,0x4,0x8,... one per cycle, instrD matches, no gaps.
//   3 Back-pressure: readyD=0 for 6 cycles mid-stream ->
//     requests stop after 2 words buffered, instrD/pcD stable.
//     readyD=1 -> sequence resumes with no skip or repeat.
//   4 Redirect: redirect=1, redirect_pc=0x103 while a response is in flight ->
//     stale word dropped, FIFO empty; next imem_addr=0x100; next pcD=0x100 at R+3.
//   5 Wrap: RESET_PC=0xFFFF_FFF8 -> pcD=0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//   6 Redirect with pop and push in the same cycle ->
//     popped word counted once; pushed word discarded; count=0 next cycle.
//     Reset asserted mid-stream -> same state as test 1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the decode stage. Owns the PC, issues one word
//   request per cycle to instruction memory (at most one outstanding), and
//   buffers returned words with their PCs in a 2-entry FIFO. The FIFO head is
//   presented to decode as {instrD, pcD}. Redirects from execute reload the PC,
//   flush the buffer and discard any wrong-path response.
//
// Ports
//   clk          in   1   clock, all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request this cycle (memory always accepts)
//   imem_addr    out  32  word-aligned fetch address (= PC)
//   imem_rvalid  in   1   response valid, one cycle after the request
//   imem_rdata   in   32  instruction word for the outstanding request
//   redirect     in   1   load redirect_pc into the PC this cycle
//   redirect_pc  in   32  redirect target, bits [1:0] ignored
//   validD       out  1   instrD/pcD hold a valid instruction
//   readyD       in   1   decode accepts the presented instruction
//   instrD       out  32  instruction word at the FIFO head
//   pcD          out  32  address of instrD
//
// Handshake: a transfer to decode happens in exactly the cycles where
//   validD & readyD are both high at the rising edge. While validD is high and
//   readyD is low, instrD/pcD/validD are held unchanged; validD never depends
//   combinationally on readyD.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        validD,
    input  logic        readyD,
    output logic [31:0] instrD,
    output logic [31:0] pcD
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [31:0] pc;
    logic [31:0] inflightPc;
    logic        inflight;
    logic        kill;

    logic [31:0] instrBuf [2];
    logic [31:0] pcBuf    [2];
    logic        rdPtr;
    logic        wrPtr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic [2:0]  occupancy;

    // The two address LSBs of a redirect target are dropped on purpose.
    logic unusedRedirectLsbs;
    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    assign validD = ~rst & (count != 2'd0);
    assign pop    = validD & readyD;

    // Words already buffered plus the one coming back, minus the one leaving.
    // Only request when the returning word is guaranteed a free slot.
    // pop implies count >= 1, so the subtraction never underflows.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign imem_req  = ~rst & ~redirect & (occupancy < DEPTH);
    assign imem_addr = pc;

    // A response is only accepted for a request we actually issued, on the
    // right path, and not in a cycle where the buffer is being flushed.
    assign push = imem_rvalid & inflight & ~kill & ~redirect & ~rst;

    assign instrD = rst ? 32'h0 : instrBuf[rdPtr];
    assign pcD    = rst ? 32'h0 : pcBuf[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= {RESET_PC[31:2], 2'b00};
            inflightPc <= 32'h0;
            inflight   <= 1'b0;
            kill       <= 1'b0;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                instrBuf[i] <= 32'h0;
                pcBuf[i]    <= 32'h0;
            end
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc         <= pc + 32'd4;
                inflightPc <= pc;
            end

            if (redirect) begin
                pc    <= {redirect_pc[31:2], 2'b00};
                count <= 2'd0;
                rdPtr <= 1'b0;
                wrPtr <= 1'b0;
                // An outstanding request whose word has not shown up yet
                // belongs to the old path; mark it for dropping.
                kill  <= inflight & ~imem_rvalid;
            end else begin
                if (imem_rvalid & kill) begin
                    kill <= 1'b0;
                end
                if (push) begin
                    instrBuf[wrPtr] <= imem_rdata;
                    pcBuf[wrPtr]    <= inflightPc;
                    wrPtr           <= ~wrPtr;
                end
                if (pop) begin
                    rdPtr <= ~rdPtr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        readyD = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        spur = 1'b0;

    // ---------------- main DUT (RESET_PC = 0) ----------------
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        memValid = 1'b0;
    logic [31:0] memData  = 32'h0;

    assign imem_rvalid = memValid | spur;
    assign imem_rdata  = memData;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .validD(validD), .readyD(readyD),
        .instrD(instrD), .pcD(pcD)
    );

    // Memory model: answers one cycle after each request, word = addr ^ key.
    always @(posedge clk) begin
        memValid <= imem_req;
        memData  <= imem_addr ^ XOR_KEY;
    end

    // ---------------- wrap DUT (RESET_PC near top of space) ----------------
    logic        wReq;
    logic [31:0] wAddr;
    logic        wRvalid = 1'b0;
    logic [31:0] wRdata  = 32'h0;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc;

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(wReq), .imem_addr(wAddr),
        .imem_rvalid(wRvalid), .imem_rdata(wRdata),
        .redirect(1'b0), .redirect_pc(32'h0),
        .validD(wValid), .readyD(1'b1),
        .instrD(wInstr), .pcD(wPc)
    );

    always @(posedge clk) begin
        wRvalid <= wReq;
        wRdata  <= wAddr ^ XOR_KEY;
    end

    // ---------------- scoreboard ----------------
    int nCmp = 0;
    int nErr = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic rdy, input logic redir,
                         input logic [31:0] rpc, input logic sp);
        @(negedge clk);
        rst         = r;
        readyD      = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        spur        = sp;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic rdy, input logic redir,
                                input logic [31:0] rpc, input logic eReq,
                                input logic [31:0] eAddr, input logic eValid,
                                input logic [31:0] ePc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
        return v;
    endfunction

    initial begin
        // reset held three cycles
        vecs[0]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[2]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        // streaming, first word visible two cycles after first request
        vecs[3]  = mk(0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0);
        vecs[5]  = mk(0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0);
        vecs[6]  = mk(0, 1, 0, 32'h0,         1, 32'hC,         1, 32'h4);
        // back-pressure for six cycles: requests stop, head holds
        vecs[7]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        vecs[8]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        vecs[9]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        vecs[10] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        vecs[11] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        vecs[12] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8);
        // release: resumes without skip or repeat
        vecs[13] = mk(0, 1, 0, 32'h0,         1, 32'h10,        1, 32'h8);
        vecs[14] = mk(0, 1, 0, 32'h0,         1, 32'h14,        1, 32'hC);
        vecs[15] = mk(0, 1, 0, 32'h0,         1, 32'h18,        1, 32'h10);
        // redirect with pop and an arriving response in the same cycle
        vecs[16] = mk(0, 1, 1, 32'h103,       0, 32'h0,         1, 32'h14);
        vecs[17] = mk(0, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0);
        vecs[18] = mk(0, 1, 0, 32'h0,         1, 32'h104,       0, 32'h0);
        vecs[19] = mk(0, 1, 0, 32'h0,         1, 32'h108,       1, 32'h100);
        vecs[20] = mk(0, 1, 0, 32'h0,         1, 32'h10C,       1, 32'h104);
        // redirect to the top of the address space, PC wraps to 0
        vecs[21] = mk(0, 1, 1, 32'hFFFF_FFFA, 0, 32'h0,         1, 32'h108);
        vecs[22] = mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0);
        vecs[23] = mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[24] = mk(0, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFF8);
        vecs[25] = mk(0, 1, 0, 32'h0,         1, 32'h4,         1, 32'hFFFF_FFFC);
        vecs[26] = mk(0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0);
        // reset mid-stream, response due in the reset cycle is lost
        vecs[27] = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        vecs[28] = mk(0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
        vecs[29] = mk(0, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0);
        vecs[30] = mk(0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0);
        vecs[31] = mk(0, 1, 0, 32'h0,         1, 32'hC,         1, 32'h4);

        // wrap instance output order
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].rst, vecs[k].rdy, vecs[k].redir, vecs[k].rpc, 1'b0);
            chk($sformatf("v%0d imem_req", k), {31'h0, imem_req}, {31'h0, vecs[k].eReq});
            chk($sformatf("v%0d validD", k), {31'h0, validD}, {31'h0, vecs[k].eValid});
            if (vecs[k].eReq)
                chk($sformatf("v%0d imem_addr", k), imem_addr, vecs[k].eAddr);
            if (vecs[k].eValid) begin
                chk($sformatf("v%0d pcD", k), pcD, vecs[k].ePc);
                chk($sformatf("v%0d instrD", k), instrD, vecs[k].ePc ^ XOR_KEY);
            end
            if (vecs[k].rst) begin
                chk($sformatf("v%0d pcD_rst", k), pcD, 32'h0);
                chk($sformatf("v%0d instrD_rst", k), instrD, 32'h0);
            end
            if (k >= 5 && exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk($sformatf("wrap%0d validD", k), {31'h0, wValid}, 32'h1);
                chk($sformatf("wrap%0d pcD", k), wPc, e);
                chk($sformatf("wrap%0d instrD", k), wInstr, e ^ XOR_KEY);
            end
        end

        // Full FIFO under back-pressure, then redirect: buffered words flushed.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 32'h0, 0);
            chk($sformatf("bpfull%0d validD", i), {31'h0, validD}, 32'h1);
            chk($sformatf("bpfull%0d pcD", i), pcD, 32'h8);
            chk($sformatf("bpfull%0d imem_req", i), {31'h0, imem_req}, 32'h0);
        end
        drive(0, 0, 1, 32'h200, 0);
        chk("redir_full imem_req", {31'h0, imem_req}, 32'h0);
        drive(0, 1, 0, 32'h0, 0);
        chk("redir_full+1 validD", {31'h0, validD}, 32'h0);
        chk("redir_full+1 imem_req", {31'h0, imem_req}, 32'h1);
        chk("redir_full+1 imem_addr", imem_addr, 32'h200);
        drive(0, 1, 0, 32'h0, 0);
        chk("redir_full+2 validD", {31'h0, validD}, 32'h0);
        drive(0, 1, 0, 32'h0, 0);
        chk("redir_full+3 validD", {31'h0, validD}, 32'h1);
        chk("redir_full+3 pcD", pcD, 32'h200);
        chk("redir_full+3 instrD", instrD, 32'h200 ^ XOR_KEY);
        drive(0, 1, 0, 32'h0, 0);
        chk("redir_full+4 pcD", pcD, 32'h204);

        // Response with nothing outstanding must be ignored.
        drive(0, 1, 1, 32'h300, 0);
        drive(0, 1, 0, 32'h0, 1);
        chk("spur imem_addr", imem_addr, 32'h300);
        chk("spur validD", {31'h0, validD}, 32'h0);
        drive(0, 1, 0, 32'h0, 0);
        chk("spur+1 validD", {31'h0, validD}, 32'h0);
        drive(0, 1, 0, 32'h0, 0);
        chk("spur+2 validD", {31'h0, validD}, 32'h1);
        chk("spur+2 pcD", pcD, 32'h300);
        chk("spur+2 instrD", instrD, 32'h300 ^ XOR_KEY);
        drive(0, 1, 0, 32'h0, 0);
        chk("spur+3 pcD", pcD, 32'h304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
